cpu_run_monitor: RTL

Synthesizable run-control and register-dump monitor for the single-cycle CPU (sccomp). It starts the CPU, counts retired instructions and halts the CPU on a programmable stop PC, a cycle timeout or an external abort. After halting, it walks the register file through the CPU's reg_sel/reg_data debug port and streams every register out on a valid/ready interface. It generalises the end-PC and timeout checks of the simulation bench into hardware with N stop addresses and a parametrised register count.

---
 rtl/cpu_run_monitor_if.sv | 14 +
 rtl/cpu_run_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor_if.sv
// Register-dump stream leaving cpu_run_monitor: one register index and value
// per valid/ready beat.
interface cpu_run_monitor_if #(
    parameter int DW     = 32,
    parameter int RSEL_W = 5
);
    logic              dump_valid;
    logic              dump_ready;
    logic [RSEL_W-1:0] dump_idx;
    logic [DW-1:0]     dump_data;

    modport master (output dump_valid, dump_idx, dump_data, input dump_ready);
    modport slave  (input dump_valid, dump_idx, dump_data, output dump_ready);
endinterface

// File: rtl/cpu_run_monitor.sv
// Run-control monitor for sccomp: runs the CPU until a stop PC, timeout or
// abort, then streams the whole register file out over the dump interface.
module cpu_run_monitor #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NREGS      = 32,
    parameter int RSEL_W     = 5,
    parameter int NBP        = 2,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [AW-1:0]         pc,
    input  logic [DW-1:0]         instr,
    input  logic                  pc_valid,
    input  logic [NBP*AW-1:0]     stop_pc,
    input  logic [NBP-1:0]        stop_en,
    output logic                  cpu_run,
    output logic [RSEL_W-1:0]     reg_sel,
    input  logic [DW-1:0]         reg_data,
    cpu_run_monitor_if.master     dump,
    output logic [31:0]           cycle_count,
    output logic [1:0]            halt_cause,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, RUN, DUMP, DRAIN, DONE} state_t;

    localparam logic [RSEL_W-1:0] LAST_IDX  = RSEL_W'(NREGS - 1);
    localparam logic [32:0]       MAX_COUNT = 33'(MAX_CYCLES);

    state_t      state;
    logic        stop_hit;
    logic [1:0]  halt_req;
    logic [31:0] count_next;
    logic        unused_instr;

    // instr is carried only so a bench can watch the retiring instruction
    assign unused_instr = ^instr;

    always_comb begin
        stop_hit = 1'b0;
        for (int k = 0; k < NBP; k++) begin
            if (stop_en[k] && (pc == stop_pc[k*AW +: AW])) begin
                stop_hit = 1'b1;
            end
        end
    end

    assign count_next = (&cycle_count) ? cycle_count : cycle_count + 32'd1;

    // Stop PC outranks timeout, which outranks abort; the halting retire is counted
    always_comb begin
        halt_req = 2'd0;
        if (pc_valid && stop_hit) begin
            halt_req = 2'd1;
        end else if (pc_valid && (({1'b0, cycle_count} + 33'd1) == MAX_COUNT)) begin
            halt_req = 2'd2;
        end else if (abort) begin
            halt_req = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            cpu_run         <= 1'b0;
            reg_sel         <= '0;
            dump.dump_valid <= 1'b0;
            dump.dump_idx   <= '0;
            dump.dump_data  <= '0;
            cycle_count     <= '0;
            halt_cause      <= 2'd0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        cpu_run     <= 1'b1;
                        cycle_count <= '0;
                        halt_cause  <= 2'd0;
                        done        <= 1'b0;
                        reg_sel     <= '0;
                    end
                end
                RUN: begin
                    if (pc_valid) begin
                        cycle_count <= count_next;
                    end
                    if (halt_req != 2'd0) begin
                        cpu_run    <= 1'b0;
                        halt_cause <= halt_req;
                        reg_sel    <= '0;
                        state      <= DUMP;
                    end
                end
                DUMP: begin
                    // Register 0 is hardwired zero in the CPU, so report it as such
                    if (!dump.dump_valid || dump.dump_ready) begin
                        dump.dump_data  <= (reg_sel == '0) ? {DW{1'b0}} : reg_data;
                        dump.dump_idx   <= reg_sel;
                        dump.dump_valid <= 1'b1;
                        if (reg_sel == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            reg_sel <= reg_sel + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dump.dump_ready) begin
                        dump.dump_valid <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
